hwpe_tcdm_mux: RTL and testbench

- Sits directly downstream of hwpe_top.
- Merges its NB_IN TCDM master ports (2 operand loads + 1 result store) onto a single physical TCDM port toward the cluster interconnect.
- Uses round-robin arbitration on the request channel.
- Routes each in-order response back to its originating port through an outstanding-transaction index FIFO.

---
 rtl/hwpe_tcdm_mux.sv | 172 +++++++++++++++++
 tb/tb_hwpe_tcdm_mux.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_tcdm_mux.sv
// hwpe_tcdm_mux: merges NB_IN TCDM master ports onto one TCDM port.
// Requests are arbitrated round-robin. Each granted port index is queued in
// an index FIFO, and the in-order responses are steered back using that FIFO.
module hwpe_tcdm_mux #(
  parameter int unsigned NB_IN           = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   clear_i,
  input  logic [NB_IN-1:0]                       in_req_i,
  output logic [NB_IN-1:0]                       in_gnt_o,
  input  logic [NB_IN*ADDR_WIDTH-1:0]            in_add_i,
  input  logic [NB_IN-1:0]                       in_wen_i,
  input  logic [NB_IN*DATA_WIDTH/8-1:0]          in_be_i,
  input  logic [NB_IN*DATA_WIDTH-1:0]            in_data_i,
  output logic [NB_IN*DATA_WIDTH-1:0]            in_r_data_o,
  output logic [NB_IN-1:0]                       in_r_valid_o,
  output logic                                   out_req_o,
  input  logic                                   out_gnt_i,
  output logic [ADDR_WIDTH-1:0]                  out_add_o,
  output logic                                   out_wen_o,
  output logic [DATA_WIDTH/8-1:0]                out_be_o,
  output logic [DATA_WIDTH-1:0]                  out_data_o,
  input  logic [DATA_WIDTH-1:0]                  out_r_data_i,
  input  logic                                   out_r_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx_mem [MAX_OUTSTANDING];
  logic             err;
  logic             full;
  logic             empty;
  logic             hs;
  logic             pop;

  // Port index + 1, wrapping at NB_IN (NB_IN need not be a power of two).
  function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NB_IN - 1)) begin
      return '0;
    end else begin
      return p + IDX_W'(1);
    end
  endfunction

  // FIFO pointer + 1, wrapping at MAX_OUTSTANDING (also covers depth 1).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // First requesting port scanning upward from ptr; port 0 when none request.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NB_IN-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] res;
    logic             found;
    cand  = ptr;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NB_IN; i++) begin
      if (!found && req[cand]) begin
        res   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
      cand = next_port(cand);
    end
    return res;
  endfunction

  assign full   = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count == CNT_W'(0));
  assign winner = rr_pick(in_req_i, rr_ptr);
  assign head   = idx_mem[rd_ptr];

  // Full blocks new requests outright; a pop only frees a slot next cycle.
  assign out_req_o  = (|in_req_i) & ~full;
  assign hs         = out_req_o & out_gnt_i;
  assign pop        = out_r_valid_i & ~empty;

  assign out_add_o  = in_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign out_wen_o  = in_wen_i[winner];
  assign out_be_o   = in_be_i[winner*BE_WIDTH +: BE_WIDTH];
  assign out_data_o = in_data_i[winner*DATA_WIDTH +: DATA_WIDTH];

  assign in_r_data_o   = {NB_IN{out_r_data_i}};
  assign outstanding_o = count;
  assign err_o         = err;

  // Grant goes only to the current winner, and only on a real handshake.
  always_comb begin
    in_gnt_o = '0;
    if (hs) begin
      in_gnt_o[winner] = 1'b1;
    end else begin
      in_gnt_o = '0;
    end
  end

  // Response valid is steered to the port at the head of the index FIFO.
  always_comb begin
    in_r_valid_o = '0;
    if (pop) begin
      in_r_valid_o[head] = 1'b1;
    end else begin
      in_r_valid_o = '0;
    end
  end

  // Arbiter pointer, FIFO pointers, occupancy and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr <= next_port(winner);
        wr_ptr <= next_ptr(wr_ptr);
      end else begin
        rr_ptr <= rr_ptr;
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({hs, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (out_r_valid_i && empty) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  // Index storage; entries beyond the pointers are never read, so no reset.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      idx_mem[wr_ptr] <= winner;
    end else begin
      idx_mem[wr_ptr] <= idx_mem[wr_ptr];
    end
  end

endmodule

// File: tb/tb_hwpe_tcdm_mux.sv
// Self-checking bench for hwpe_tcdm_mux: directed scenarios followed by a
// randomized phase, checked against a queue-based reference model and a
// response scoreboard consumed by an independent monitor.
module tb_hwpe_tcdm_mux;

  localparam int NB   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic [NB-1:0]     in_req;
  logic [NB-1:0]     in_gnt;
  logic [NB*AW-1:0]  in_add;
  logic [NB-1:0]     in_wen;
  logic [NB*BW-1:0]  in_be;
  logic [NB*DW-1:0]  in_data;
  logic [NB*DW-1:0]  in_r_data;
  logic [NB-1:0]     in_r_valid;
  logic              out_req;
  logic              out_gnt;
  logic [AW-1:0]     out_add;
  logic              out_wen;
  logic [BW-1:0]     out_be;
  logic [DW-1:0]     out_data;
  logic [DW-1:0]     out_r_data;
  logic              out_r_valid;
  logic [CW-1:0]     outstanding;
  logic              err;

  hwpe_tcdm_mux #(
    .NB_IN(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
    .in_be_i(in_be), .in_data_i(in_data), .in_r_data_o(in_r_data),
    .in_r_valid_o(in_r_valid), .out_req_o(out_req), .out_gnt_i(out_gnt),
    .out_add_o(out_add), .out_wen_o(out_wen), .out_be_o(out_be),
    .out_data_o(out_data), .out_r_data_i(out_r_data), .out_r_valid_i(out_r_valid),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  // Reference model state
  int          m_rr;
  int          m_q[$];
  bit          m_err;
  exp_t        sb[$];
  bit          hs_pred;
  int          w_pred;
  logic [31:0] next_rdata;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting port scanning from the model's round-robin pointer.
  function automatic int model_winner();
    for (int i = 0; i < NB; i++) begin
      int c = (m_rr + i) % NB;
      if (in_req[c]) return c;
    end
    return -1;
  endfunction

  // Compare all request-side outputs and status against the model.
  task automatic check();
    int w;
    bit exp_req;
    logic [NB-1:0] exp_gnt;
    w       = model_winner();
    exp_req = (w >= 0) && (m_q.size() < MAXO);
    exp_gnt = '0;
    if (exp_req && out_gnt) exp_gnt[w] = 1'b1;
    cmp("out_req", 64'(out_req), 64'(exp_req));
    cmp("in_gnt", 64'(in_gnt), 64'(exp_gnt));
    cmp("outstanding", 64'(outstanding), 64'(m_q.size()));
    cmp("err", 64'(err), 64'(m_err));
    if (exp_req) begin
      cmp("out_add", 64'(out_add), 64'(in_add[w*AW +: AW]));
      cmp("out_wen", 64'(out_wen), 64'(in_wen[w]));
      cmp("out_be", 64'(out_be), 64'(in_be[w*BW +: BW]));
      cmp("out_data", 64'(out_data), 64'(in_data[w*DW +: DW]));
    end
    hs_pred = exp_req && out_gnt;
    w_pred  = w;
  endtask

  // Advance the model by one clock edge.
  task automatic update();
    if (rst || clear) begin
      m_q.delete();
      sb.delete();
      m_rr  = 0;
      m_err = 1'b0;
      hs_pred = 1'b0;
    end else begin
      if (out_r_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (hs_pred) begin
        exp_t e;
        e.port = w_pred;
        e.data = next_rdata;
        m_q.push_back(w_pred);
        sb.push_back(e);
        m_rr = (w_pred + 1) % NB;
        next_rdata = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic set_req(input int k, input bit r, input logic [31:0] a);
    in_req[k]          = r;
    in_add[k*AW +: AW] = a;
    in_wen[k]          = a[0];
    in_be[k*BW +: BW]  = a[7:4];
    in_data[k*DW +: DW] = ~a;
  endtask

  task automatic new_txn(input int k);
    in_req[k]           = 1'b1;
    in_add[k*AW +: AW]  = $urandom;
    in_wen[k]           = 1'($urandom_range(1, 0));
    in_be[k*BW +: BW]   = BW'($urandom);
    in_data[k*DW +: DW] = $urandom;
  endtask

  // Interconnect response stub: returns the oldest outstanding transaction's data.
  task automatic respond(input bit v);
    out_r_valid = v;
    out_r_data  = (sb.size() > 0) ? sb[0].data : $urandom;
  endtask

  // Response monitor: pops the scoreboard whenever a valid response is routed.
  always @(negedge clk) begin
    if (started) begin
      if (out_r_valid && sb.size() > 0) begin
        exp_t e;
        logic [NB-1:0] oh;
        e  = sb.pop_front();
        oh = '0;
        oh[e.port] = 1'b1;
        cmp("r_valid_route", 64'(in_r_valid), 64'(oh));
        cmp("r_data", 64'(in_r_data[e.port*DW +: DW]), 64'(e.data));
      end else begin
        cmp("r_valid_idle", 64'(in_r_valid), 64'd0);
      end
    end
  end

  logic [NB-1:0] exp_oh;
  logic [NB-1:0] prev_oh;

  initial begin
    rst = 1'b1; clear = 1'b0; in_req = '0; in_add = '0; in_wen = '0; in_be = '0;
    in_data = '0; out_gnt = 1'b0; out_r_valid = 1'b0; out_r_data = '0;
    m_rr = 0; m_err = 1'b0; hs_pred = 1'b0; w_pred = 0; next_rdata = $urandom;
    exp_oh = 3'b001; prev_oh = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    started = 1'b1;
    cmp("rst_outstanding", 64'(outstanding), 64'd0);
    cmp("rst_err", 64'(err), 64'd0);
    cmp("rst_out_req", 64'(out_req), 64'd0);

    // Single port read with a one-cycle response.
    set_req(1, 1'b1, 32'h0000_0101); out_gnt = 1'b1; next_rdata = 32'hDEAD_BEEF; respond(1'b0);
    #1;
    cmp("t1_gnt", 64'(in_gnt), 64'h2);
    cmp("t1_occ0", 64'(outstanding), 64'd0);
    cmp("t1_add", 64'(out_add), 64'h101);
    tick();
    set_req(1, 1'b0, 32'h0000_0101); out_gnt = 1'b0; respond(1'b1);
    #1;
    cmp("t1_occ1", 64'(outstanding), 64'd1);
    cmp("t1_rvalid", 64'(in_r_valid), 64'h2);
    cmp("t1_rdata", 64'(in_r_data[DW +: DW]), 64'hDEAD_BEEF);
    tick();
    respond(1'b0);
    #1;
    cmp("t1_occ_back", 64'(outstanding), 64'd0);

    // Fairness: all ports request continuously, responses one cycle after grant.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < NB; k++) set_req(k, 1'b1, 32'h0000_1000 + 32'(k * 4));
    out_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      respond(i > 0);
      #1;
      cmp("fair_gnt", 64'(in_gnt), 64'(exp_oh));
      if (i > 0) cmp("fair_route", 64'(in_r_valid), 64'(prev_oh));
      tick();
      prev_oh = exp_oh;
      exp_oh  = {exp_oh[1:0], exp_oh[2]};
    end
    in_req = '0; out_gnt = 1'b0; respond(1'b1); tick(); respond(1'b0);

    // Backpressure on port 2.
    set_req(2, 1'b1, 32'h2000_0040);
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp("bp_req", 64'(out_req), 64'd1);
      cmp("bp_add", 64'(out_add), 64'h2000_0040);
      cmp("bp_gnt", 64'(in_gnt), 64'd0);
      tick();
    end
    out_gnt = 1'b1; #1; cmp("bp_release_gnt", 64'(in_gnt), 64'h4); tick();
    set_req(2, 1'b0, 32'h0); out_gnt = 1'b0; respond(1'b1); tick(); respond(1'b0);

    // Full FIFO with no bypass on pop.
    clear = 1'b1; tick(); clear = 1'b0;
    set_req(0, 1'b1, 32'h0000_0200); out_gnt = 1'b1;
    repeat (4) tick();
    #1;
    cmp("full_occ", 64'(outstanding), 64'd4);
    cmp("full_req", 64'(out_req), 64'd0);
    cmp("full_gnt", 64'(in_gnt), 64'd0);
    tick();
    respond(1'b1);
    #1;
    cmp("full_pop_nobypass", 64'(out_req), 64'd0);
    tick();
    respond(1'b0);
    #1;
    cmp("full_resume", 64'(out_req), 64'd1);
    cmp("full_occ3", 64'(outstanding), 64'd3);
    tick();
    set_req(0, 1'b0, 32'h0); out_gnt = 1'b0;
    repeat (4) begin respond(1'b1); tick(); end
    respond(1'b0);

    // Push and pop in the same cycle at occupancy 2.
    set_req(1, 1'b1, 32'h0000_0300); out_gnt = 1'b1;
    repeat (2) tick();
    set_req(1, 1'b0, 32'h0); set_req(2, 1'b1, 32'h0000_0310); respond(1'b1);
    #1; cmp("pp_occ_before", 64'(outstanding), 64'd2);
    tick();
    set_req(2, 1'b0, 32'h0); out_gnt = 1'b0; respond(1'b1);
    #1; cmp("pp_occ_after", 64'(outstanding), 64'd2);
    tick();
    respond(1'b1); tick(); respond(1'b0);

    // Spurious response, then clear mid-burst at occupancy 3.
    respond(1'b1);
    #1;
    cmp("spur_rvalid", 64'(in_r_valid), 64'd0);
    cmp("spur_err_before", 64'(err), 64'd0);
    tick();
    respond(1'b0);
    #1; cmp("spur_err_set", 64'(err), 64'd1);
    set_req(1, 1'b1, 32'h0000_0400); out_gnt = 1'b1;
    repeat (3) tick();
    #1; cmp("clr_occ3", 64'(outstanding), 64'd3);
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < NB; k++) set_req(k, 1'b1, 32'h0000_0500 + 32'(k * 16));
    #1;
    cmp("clr_occ", 64'(outstanding), 64'd0);
    cmp("clr_err", 64'(err), 64'd0);
    cmp("clr_rr", 64'(in_gnt), 64'h1);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (hs_pred) begin
        if ($urandom_range(1, 0) == 0) in_req[w_pred] = 1'b0;
        else new_txn(w_pred);
      end
      for (int k = 0; k < NB; k++) begin
        if (!in_req[k] && $urandom_range(3, 0) == 0) new_txn(k);
      end
      out_gnt = ($urandom_range(3, 0) != 0);
      if (sb.size() > 0) respond($urandom_range(2, 0) != 0);
      else respond($urandom_range(63, 0) == 0);
      clear = ($urandom_range(499, 0) == 0);
      tick();
    end

    // Drain.
    clear = 1'b0; in_req = '0; out_gnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() > 0) begin respond(1'b1); tick(); end
    end
    respond(1'b0); tick();
    cmp("drain_sb_empty", 64'(sb.size()), 64'd0);
    cmp("drain_occ", 64'(outstanding), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
